change_event_logger: RTL
========================

# change_event_logger

Synchronous change-event capture stage for two monitored buses, `a_in` and `b_in`. The block samples both buses every clock and detects any change in either one (an OR of events). For each change it records the new values, a mask of which bus changed, and a cycle timestamp. Events are buffered in a FIFO and drained over a valid/ready port to a downstream consumer, such as a trace/display formatter or a bus bridge. It is the synthesizable counterpart of an `always @(a or b)` monitor.

## Interface
- `WIDTH`, 2, width of each monitored bus
- `TS_WIDTH`, 16, timestamp counter width
- `DEPTH`, 8, FIFO entries; power of two, ≥2
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `a_in`  in  WIDTH  monitored bus A, synchronous to `clk`
- `b_in`  in  WIDTH  monitored bus B, synchronous to `clk`
- `ev_valid`  out  1  head event available
- `ev_ready`  in  1  consumer accepts head event
- `ev_a`  out  WIDTH  value of A after the change
- `ev_b`  out  WIDTH  value of B after the change
- `ev_mask`  out  2  bit0 = A changed, bit1 = B changed
- `ev_ts`  out  TS_WIDTH  timestamp of the change
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy
- `overflow`  out  1  sticky flag: an event was dropped
- `clr_ovf`  in  1  clears `overflow` (and the drop counter)
- `drop_cnt`  out  8  dropped-event count; see Configuration

## Operation
- Holding registers `a_q`, `b_q` and flag `armed`. Reset values: `a_q`, `b_q` = 0; `armed` = 0.
- Timestamp counter `ts_cnt`:
  - Reset value 0.
  - Increments every clock.
  - Wraps from 2^TS_WIDTH−1 to 0 with no flag.
- Detection at each edge:
  - mask = {`b_in`≠`b_q`, `a_in`≠`a_q`}.
  - If `armed` = 0, mask is forced to 2'b11. This is the first sample after reset and always logs one event.
  - Change = (mask ≠ 0).
- On a change, push entry {`a_in`, `b_in`, mask, `ts_cnt`}.
- `a_q` ← `a_in` and `b_q` ← `b_in` every cycle; `armed` ← 1 after the first edge.
- No change means no push. Repeated identical values never log.
- Both buses changing in the same cycle produce one event with mask 2'b11, not two.
- Pop: when `ev_valid` && `ev_ready`.
- Full and push without pop:
  - The new event is dropped; FIFO contents are unchanged.
  - `overflow` ← 1.
  - `drop_cnt` increments, saturating at 255.
- Full, push and pop in the same cycle: both occur, nothing is dropped, level stays DEPTH.
- Empty, push and pop in the same cycle: the pop is ignored because `ev_valid` = 0. Push proceeds and level becomes 1.
- `clr_ovf` and a drop in the same cycle: the drop wins; `overflow` = 1 and `drop_cnt` = 1.
- `ev_*` outputs are don't-care while `ev_valid` = 0.

## Timing
- Show-ahead FIFO: the head entry drives `ev_a`, `ev_b`, `ev_mask`, `ev_ts` combinationally from storage.
- Latency: a new value present on the inputs in the cycle where `ts_cnt` = T gives `ev_valid` = 1 in the next cycle, carrying `ev_ts` = T (empty FIFO).
- `level` updates on the edge after a push or pop.
- Sustained throughput: one event per cycle in, one out.
- Reset values of all outputs:
  - `ev_valid` = 0, `level` = 0, `overflow` = 0, `drop_cnt` = 0.
  - `ev_*` data = 0.
- Reset asserted mid-operation:
  - Immediately (asynchronously) empties the FIFO and zeroes `ts_cnt`, `a_q`, `b_q`, `armed`, `overflow`, `drop_cnt`.
  - Events already queued are lost.
  - After reset deasserts, the first edge logs a mask=11 event again.

## Configuration
- Macro: `CHANGE_EVENT_LOGGER_DROP_CNT_EN`.
- Defined: the 8-bit saturating drop counter is implemented as above.
- Undefined: the counter is not built and `drop_cnt` is tied to 0. `overflow` behaves identically in both builds.

## Structure
- Package `change_event_logger_pkg`:
  - mask bit-index constants `MASK_A` = 0, `MASK_B` = 1
  - default `WIDTH` / `TS_WIDTH` / `DEPTH` constants
  - `DROP_CNT_W` = 8
- One sub-module, `evlog_fifo`:
  - parameterized width/depth, show-ahead, async-reset
  - ports: push/pop/din/dout/full/empty/level
  - the top level holds the detection logic, timestamp counter and overflow logic.

## Test plan
- **First event after reset:** deassert reset with a=0, b=0 → one event {a=0, b=0, mask=11, ts=0}; no further events while inputs hold.
- **Single-bus changes:** at ts=10 drive b=1; at ts=20 drive a=1; at ts=40 rewrite a=1, b=1 → events (0,1,10,ts=10) and (1,1,01,ts=20); nothing at ts=40.
- **Simultaneous change:** at ts=70 go from a=1, b=1 to a=2, b=3 → exactly one event {2, 3, mask=11, ts=70}.
- **Overflow with `ev_ready` = 0:**
  - Toggle a every cycle for DEPTH+3 changes → level = 8, `overflow` = 1, `drop_cnt` = 3 (macro on) or 0 (macro off).
  - The queued entries are the first 8 events in order.
  - `clr_ovf` clears the flag.
- **Full with simultaneous push/pop:** `ev_ready` = 1 with a change every cycle → no drops, level holds at 8, timestamps are consecutive.
- **Reset mid-operation:** assert reset with 5 events queued → `ev_valid` drops with no clock edge; after release, the first event has ts=0 and mask=11.

Source files
------------

// File: rtl/change_event_logger_pkg.sv
// Shared constants and helpers for the change-event logger.
// The optional drop counter is controlled by CHANGE_EVENT_LOGGER_DROP_CNT_EN.
package change_event_logger_pkg;

  localparam int MASK_A       = 0;
  localparam int MASK_B       = 1;
  localparam int DEF_WIDTH    = 2;
  localparam int DEF_TS_WIDTH = 16;
  localparam int DEF_DEPTH    = 8;
  localparam int DROP_CNT_W   = 8;

  // Saturating increment used by the drop counter.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/evlog_fifo.sv
// Show-ahead FIFO with asynchronous reset; head entry is driven straight from storage.
// A push while full is only accepted when a pop frees the head slot in the same cycle.
module evlog_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          wr_en;
  logic          rd_en;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign level = count;
  assign dout  = mem[rd_ptr];

  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/change_event_logger.sv
// Detects changes on two buses, timestamps them and queues events for a valid/ready consumer.
// Define CHANGE_EVENT_LOGGER_DROP_CNT_EN to build the saturating dropped-event counter.
module change_event_logger
  import change_event_logger_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int TS_WIDTH = DEF_TS_WIDTH,
  parameter int DEPTH    = DEF_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        a_in,
  input  logic [WIDTH-1:0]        b_in,
  // ev_valid/ev_ready: the head event transfers on any edge where both are high;
  // ev_valid never depends on ev_ready, and ev_* are meaningless while ev_valid is low.
  output logic                    ev_valid,
  input  logic                    ev_ready,
  output logic [WIDTH-1:0]        ev_a,
  output logic [WIDTH-1:0]        ev_b,
  output logic [1:0]              ev_mask,
  output logic [TS_WIDTH-1:0]     ev_ts,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  input  logic                    clr_ovf,
  output logic [DROP_CNT_W-1:0]   drop_cnt
);

  localparam int EW = 2*WIDTH + 2 + TS_WIDTH;

  logic [WIDTH-1:0]    a_q;
  logic [WIDTH-1:0]    b_q;
  logic                armed;
  logic [TS_WIDTH-1:0] ts_cnt;
  logic [1:0]          mask;
  logic                change;
  logic                pop;
  logic                drop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [EW-1:0]       fifo_din;
  logic [EW-1:0]       fifo_dout;

  // Until the first sample is taken both buses count as changed.
  always_comb begin
    mask         = 2'b00;
    mask[MASK_A] = (a_in != a_q);
    mask[MASK_B] = (b_in != b_q);
    if (!armed) mask = 2'b11;
  end

  assign change   = |mask;
  assign ev_valid = !fifo_empty;
  assign pop      = ev_valid && ev_ready;
  assign drop     = change && fifo_full && !pop;
  assign fifo_din = {a_in, b_in, mask, ts_cnt};
  assign {ev_a, ev_b, ev_mask, ev_ts} = fifo_dout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      armed  <= 1'b0;
      ts_cnt <= '0;
    end else begin
      a_q    <= a_in;
      b_q    <= b_in;
      armed  <= 1'b1;
      ts_cnt <= ts_cnt + 1'b1;
    end
  end

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

`ifdef CHANGE_EVENT_LOGGER_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          drop_cnt_q <= '0;
    else if (drop)    drop_cnt_q <= clr_ovf ? DROP_CNT_W'(1) : sat_inc(drop_cnt_q);
    else if (clr_ovf) drop_cnt_q <= '0;
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = '0;
`endif

  evlog_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (change),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

endmodule
